// File: rtl/modbus_pkg.sv
// Shared types and field widths for the Modbus poll scheduler.
package modbus_pkg;

    localparam int unsigned ADR_W   = 8;
    localparam int unsigned REG_W   = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RETRY_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        GAP
    } state_t;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [REG_W-1:0] adr_tx;
        logic [CNT_W-1:0] num_tx;
        logic [REG_W-1:0] adr_rx;
        logic [CNT_W-1:0] num_rx;
    } desc_t;

    // Counter width for a count of n cycles; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/modbus_poll_scheduler_if.sv
// Transaction handshake between the poll scheduler and the Modbus RTU master.
interface modbus_poll_scheduler_if #(
    parameter int unsigned SEL_W = 4
);
    import modbus_pkg::*;

    logic             start;
    logic             done;
    logic             error;
    logic [SEL_W-1:0] slave_idx;
    logic [ADR_W-1:0] adr;
    logic [REG_W-1:0] adr_first_reg_tx;
    logic [CNT_W-1:0] num_reg_tx;
    logic [REG_W-1:0] adr_first_reg_rx;
    logic [CNT_W-1:0] num_reg_rx;

    modport master (
        output start, slave_idx, adr, adr_first_reg_tx, num_reg_tx,
               adr_first_reg_rx, num_reg_rx,
        input  done, error
    );

    modport slave (
        input  start, slave_idx, adr, adr_first_reg_tx, num_reg_tx,
               adr_first_reg_rx, num_reg_rx,
        output done, error
    );

endinterface

// File: rtl/poll_timer.sv
// Loadable saturating down-counter; expired is high while the count is zero.
module poll_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         run,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/modbus_poll_scheduler.sv
// Round-robin poll sequencer: loads one slave descriptor at a time into the
// Modbus RTU master, retries failing slaves and keeps a per-slave link status.
module modbus_poll_scheduler
    import modbus_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned GAP_CYCLES     = 2000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [ADR_W*NUM_SLAVES-1:0] cfg_adr,
    input  logic [REG_W*NUM_SLAVES-1:0] cfg_adr_tx,
    input  logic [CNT_W*NUM_SLAVES-1:0] cfg_num_tx,
    input  logic [REG_W*NUM_SLAVES-1:0] cfg_adr_rx,
    input  logic [CNT_W*NUM_SLAVES-1:0] cfg_num_rx,
    modbus_poll_scheduler_if.master     txn,
    output logic [NUM_SLAVES-1:0]       link_ok,
    output logic                        cycle_done,
    output logic                        busy
);
    localparam int unsigned TMO_W = cnt_w(TIMEOUT_CYCLES);
    localparam int unsigned GAP_W = cnt_w(GAP_CYCLES);

    state_t                state;
    logic [RETRY_W-1:0]    retry;
    desc_t                 sel;
    logic [NUM_SLAVES-1:0] cur_mask;
    logic [SEL_W-1:0]      next_idx;
    logic                  last_slave;
    logic                  success;
    logic                  failure;
    logic                  tmo_load, tmo_run, tmo_expired;
    logic                  gap_load, gap_run, gap_expired;

    always_comb begin
        sel      = '0;
        cur_mask = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (txn.slave_idx == SEL_W'(i)) begin
                cur_mask[i] = 1'b1;
                sel.adr     = cfg_adr[i*ADR_W +: ADR_W];
                sel.adr_tx  = cfg_adr_tx[i*REG_W +: REG_W];
                sel.num_tx  = cfg_num_tx[i*CNT_W +: CNT_W];
                sel.adr_rx  = cfg_adr_rx[i*REG_W +: REG_W];
                sel.num_rx  = cfg_num_rx[i*CNT_W +: CNT_W];
            end
        end
    end

    // done/error override a coinciding timeout; done with error is a failure.
    always_comb begin
        last_slave = (txn.slave_idx == SEL_W'(NUM_SLAVES - 1));
        next_idx   = last_slave ? '0 : txn.slave_idx + 1'b1;
        success    = txn.done && !txn.error;
        failure    = txn.error || (tmo_expired && !txn.done);
        tmo_load   = (state == START);
        tmo_run    = (state == WAIT);
        gap_load   = (state == WAIT) && (success || failure);
        gap_run    = (state == GAP);
    end

    poll_timer #(.W(TMO_W)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (tmo_load),
        .load_value (TMO_W'(TIMEOUT_CYCLES - 1)),
        .run        (tmo_run),
        .expired    (tmo_expired)
    );

    poll_timer #(.W(GAP_W)) u_gap (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_W'(GAP_CYCLES - 1)),
        .run        (gap_run),
        .expired    (gap_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            retry                <= '0;
            txn.slave_idx        <= '0;
            txn.start            <= 1'b0;
            txn.adr              <= '0;
            txn.adr_first_reg_tx <= '0;
            txn.num_reg_tx       <= '0;
            txn.adr_first_reg_rx <= '0;
            txn.num_reg_rx       <= '0;
            link_ok              <= '0;
            cycle_done           <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            txn.start  <= 1'b0;
            cycle_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    txn.adr              <= sel.adr;
                    txn.adr_first_reg_tx <= sel.adr_tx;
                    txn.num_reg_tx       <= sel.num_tx;
                    txn.adr_first_reg_rx <= sel.adr_rx;
                    txn.num_reg_rx       <= sel.num_rx;
                    txn.start            <= 1'b1;
                    state                <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (success || failure) begin
                        state <= GAP;
                        if (failure && (retry < RETRY_W'(MAX_RETRY))) begin
                            retry <= retry + 1'b1;
                        end else begin
                            link_ok       <= success ? (link_ok | cur_mask)
                                                     : (link_ok & ~cur_mask);
                            retry         <= '0;
                            txn.slave_idx <= next_idx;
                            cycle_done    <= last_slave;
                        end
                    end
                end
                GAP: begin
                    if (gap_expired) begin
                        if (enable) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            retry <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_poll_scheduler.sv
// Self-checking bench for modbus_poll_scheduler: cycle-numbered reference model
// plus directed poll scenarios with hand-computed expectations.
module tb_modbus_poll_scheduler;

    localparam int NS  = 3;
    localparam int SW  = 4;
    localparam int TMO = 20;
    localparam int GAP = 4;
    localparam int MR  = 1;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;
    localparam int K_RST  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [8*NS-1:0]  cfg_adr;
    logic [16*NS-1:0] cfg_adr_tx;
    logic [8*NS-1:0]  cfg_num_tx;
    logic [16*NS-1:0] cfg_adr_rx;
    logic [8*NS-1:0]  cfg_num_rx;
    logic [NS-1:0]    link_ok;
    logic             cycle_done;
    logic             busy;

    modbus_poll_scheduler_if #(.SEL_W(SW)) txn ();

    modbus_poll_scheduler #(
        .NUM_SLAVES     (NS),
        .SEL_W          (SW),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP),
        .MAX_RETRY      (MR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_adr    (cfg_adr),
        .cfg_adr_tx (cfg_adr_tx),
        .cfg_num_tx (cfg_num_tx),
        .cfg_adr_rx (cfg_adr_rx),
        .cfg_num_rx (cfg_num_rx),
        .txn        (txn),
        .link_ok    (link_ok),
        .cycle_done (cycle_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: event times as absolute cycle numbers.
    int            m_sched = -1;
    int            m_gap_end = -1;
    int            m_cd_at = -1;
    bit            m_busy = 0;
    bit            m_wait = 0;
    int            m_slave = 0;
    int            m_retry = 0;
    logic [NS-1:0] m_link = '0;
    logic [7:0]    m_adr = '0, m_ntx = '0, m_nrx = '0;
    logic [15:0]   m_atx = '0, m_arx = '0;

    always @(negedge clk) begin
        bit ok, bad;
        if (!reset) begin
            m_sched = -1; m_gap_end = -1; m_cd_at = -1;
            m_busy = 0; m_wait = 0; m_slave = 0; m_retry = 0; m_link = '0;
            m_adr = '0; m_ntx = '0; m_nrx = '0; m_atx = '0; m_arx = '0;
        end
        check("start",      64'(txn.start),            64'(cyc == m_sched));
        check("busy",       64'(busy),                 64'(m_busy));
        check("slave_idx",  64'(txn.slave_idx),        64'(m_slave));
        check("link_ok",    64'(link_ok),              64'(m_link));
        check("cycle_done", 64'(cycle_done),           64'(cyc == m_cd_at));
        check("adr",        64'(txn.adr),              64'(m_adr));
        check("adr_tx",     64'(txn.adr_first_reg_tx), 64'(m_atx));
        check("num_tx",     64'(txn.num_reg_tx),       64'(m_ntx));
        check("adr_rx",     64'(txn.adr_first_reg_rx), 64'(m_arx));
        check("num_rx",     64'(txn.num_reg_rx),       64'(m_nrx));
        if (reset) begin
            if (!m_busy) begin
                if (enable) begin
                    m_busy  = 1;
                    m_sched = cyc + 2;
                end
            end else begin
                if (cyc == m_sched - 1) begin
                    m_adr = cfg_adr[m_slave*8 +: 8];
                    m_atx = cfg_adr_tx[m_slave*16 +: 16];
                    m_ntx = cfg_num_tx[m_slave*8 +: 8];
                    m_arx = cfg_adr_rx[m_slave*16 +: 16];
                    m_nrx = cfg_num_rx[m_slave*8 +: 8];
                end
                if (m_wait && cyc > m_sched) begin
                    ok  = txn.done && !txn.error;
                    bad = txn.error || ((cyc - m_sched == TMO) && !txn.done);
                    if (ok || bad) begin
                        m_wait    = 0;
                        m_gap_end = cyc + GAP;
                        if (ok || m_retry == MR) begin
                            m_link[m_slave] = ok;
                            m_retry = 0;
                            if (m_slave == NS - 1) begin
                                m_slave = 0;
                                m_cd_at = cyc + 1;
                            end else begin
                                m_slave++;
                            end
                        end else begin
                            m_retry++;
                        end
                    end
                end
                if (cyc == m_sched) m_wait = 1;
                if (cyc == m_gap_end) begin
                    if (enable) m_sched = cyc + 2;
                    else begin
                        m_busy  = 0;
                        m_retry = 0;
                    end
                end
            end
        end
    end

    int n_cd = 0;
    always @(negedge clk) if (reset && cycle_done) n_cd++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next start pulse, then answers it as directed by kind.
    task automatic attempt(input int kind, input int k, input bit drop,
                           output int sc, output int si, output int sa);
        int n = 0;
        while (txn.start !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("start_seen", 64'(txn.start), 64'(1));
        sc = cyc;
        si = int'(txn.slave_idx);
        sa = int'(txn.adr);
        if (kind == K_NONE) begin
            repeat (TMO + 1) tick();
        end else begin
            repeat (k) begin
                tick();
                if (drop) enable = 1'b0;
            end
            if (kind == K_RST) begin
                reset = 1'b0;
            end else begin
                txn.done  = (kind == K_DONE) || (kind == K_BOTH);
                txn.error = (kind == K_ERR)  || (kind == K_BOTH);
                tick();
                txn.done  = 1'b0;
                txn.error = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e_cyc, sc, prev, si, sa;
        txn.done   = 1'b0;
        txn.error  = 1'b0;
        cfg_adr    = {8'd3, 8'd2, 8'd1};
        cfg_adr_tx = {16'd500, 16'd400, 16'd300};
        cfg_num_tx = {8'd4, 8'd3, 8'd2};
        cfg_adr_rx = {16'd1200, 16'd1100, 16'd1000};
        cfg_num_rx = {8'd7, 8'd6, 8'd5};
        #2 reset = 1'b0;
        repeat (3) tick();
        check("rst_start", 64'(txn.start), 64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_adr",   64'(txn.adr),   64'(0));
        check("rst_link",  64'(link_ok),   64'(0));

        reset  = 1'b1;
        enable = 1'b1;
        e_cyc  = cyc;

        // Round 1: every slave answers in its 6th WAIT cycle.
        attempt(K_DONE, 6, 0, sc, si, sa);
        check("lat_start", 64'(sc - e_cyc), 64'(2));
        check("r1_idx0",   64'(si), 64'(0));
        check("r1_adr0",   64'(sa), 64'(1));
        check("r1_tx0",    64'(txn.adr_first_reg_tx), 64'(300));
        prev = sc;
        attempt(K_DONE, 6, 0, sc, si, sa);
        check("r1_space1", 64'(sc - prev), 64'(12));
        check("r1_idx1",   64'(si), 64'(1));
        check("r1_adr1",   64'(sa), 64'(2));
        prev = sc;
        attempt(K_DONE, 6, 0, sc, si, sa);
        check("r1_space2", 64'(sc - prev), 64'(12));
        check("r1_idx2",   64'(si), 64'(2));
        attempt(K_DONE, 6, 0, sc, si, sa);
        check("r1_wrap_idx", 64'(si), 64'(0));
        check("r1_link",     64'(link_ok), 64'(3'b111));
        check("r1_ncd",      64'(n_cd), 64'(1));

        // Slave 1 never answers: one retry, then marked down.
        attempt(K_NONE, 0, 0, sc, si, sa);
        check("to_idx_a", 64'(si), 64'(1));
        check("to_adr_a", 64'(sa), 64'(2));
        prev = sc;
        attempt(K_NONE, 0, 0, sc, si, sa);
        check("to_idx_b",  64'(si), 64'(1));
        check("to_space",  64'(sc - prev), 64'(26));
        check("to_link",   64'(link_ok), 64'(3'b101));
        check("to_adv",    64'(txn.slave_idx), 64'(2));

        // Slave 2: error then success; its config changes between attempts.
        attempt(K_ERR, 3, 0, sc, si, sa);
        check("er_idx_a",  64'(si), 64'(2));
        check("er_nrx_a",  64'(txn.num_reg_rx), 64'(7));
        cfg_num_rx[23:16] = 8'd9;
        attempt(K_DONE, 6, 0, sc, si, sa);
        check("er_idx_b",  64'(si), 64'(2));
        check("er_nrx_b",  64'(txn.num_reg_rx), 64'(9));
        tick();
        check("er_link",   64'(link_ok), 64'(3'b101));
        check("er_ncd",    64'(n_cd), 64'(2));

        // Slave 0: done+error together is a failure; spurious done during GAP.
        attempt(K_BOTH, 4, 0, sc, si, sa);
        check("both_idx_a", 64'(si), 64'(0));
        attempt(K_DONE, 2, 0, sc, si, sa);
        check("both_idx_b", 64'(si), 64'(0));
        tick();
        txn.done = 1'b1;
        tick();
        txn.done = 1'b0;

        // Slave 1: enable dropped during WAIT, transaction still completes.
        attempt(K_DONE, 6, 1, sc, si, sa);
        check("dis_idx",   64'(si), 64'(1));
        check("dis_busy_gap", 64'(busy), 64'(1));
        repeat (GAP) tick();
        check("dis_busy",  64'(busy), 64'(0));
        check("dis_link",  64'(link_ok), 64'(3'b111));
        check("dis_idx_after", 64'(txn.slave_idx), 64'(2));
        repeat (5) tick();
        check("dis_idle",  64'(busy), 64'(0));

        // Re-enable resumes at slave 2; reset asserted during WAIT.
        enable = 1'b1;
        attempt(K_RST, 3, 0, sc, si, sa);
        check("resume_idx", 64'(si), 64'(2));
        check("resume_adr", 64'(sa), 64'(3));
        #1;
        check("mr_busy",  64'(busy),          64'(0));
        check("mr_idx",   64'(txn.slave_idx), 64'(0));
        check("mr_link",  64'(link_ok),       64'(0));
        check("mr_adr",   64'(txn.adr),       64'(0));
        check("mr_start", 64'(txn.start),     64'(0));
        enable = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("end_busy", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
